// File: rtl/ram_program_loader_if.sv
// Word stream into the program loader and the write-side RAM bus out of it.
// master = loader side, slave = stream source / RAM side.
interface ram_program_loader_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;

    modport master (
        input  in_data, in_valid,
        output in_ready, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
    );
endinterface

// File: rtl/ram_program_loader.sv
// Boot loader: takes a framed program image off a valid/ready stream, writes it
// into program RAM, verifies an additive checksum and reports the start PC.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | waiting for load_start after reset
//   S_HDR_ADDR | expecting W0, the image base address
//   S_HDR_LEN  | expecting W1, the data word count N
//   S_DATA     | writing data words, remaining count in rem_cnt
//   S_CSUM     | expecting the checksum word
//   S_DONE     | image loaded and checksum good; pc_start valid
//   S_ERR      | checksum mismatch; image contents untrusted
module ram_program_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_start,
    ram_program_loader_if.master   bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH-1:0]  pc_start,
    output logic [DATA_WIDTH-1:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_ADDR,
        S_HDR_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [DATA_WIDTH-1:0] rem_cnt;
    logic [DATA_WIDTH-1:0] checksum;
    logic                  xfer;

    assign xfer = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rem_cnt       <= '0;
            checksum      <= '0;
            bus.in_ready  <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_cs    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_oe    <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            pc_start      <= '0;
            words_loaded  <= '0;
        end else begin
            // Write strobe lives for exactly the cycle after each data transfer.
            bus.ram_cs <= 1'b0;
            bus.ram_we <= 1'b0;
            bus.ram_oe <= 1'b1;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_start) begin
                        state        <= S_HDR_ADDR;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        checksum     <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                S_HDR_ADDR: begin
                    if (xfer) begin
                        pc_start <= bus.in_data[ADDR_WIDTH-1:0];
                        wr_ptr   <= bus.in_data[ADDR_WIDTH-1:0];
                        state    <= S_HDR_LEN;
                    end
                end

                S_HDR_LEN: begin
                    if (xfer) begin
                        rem_cnt <= bus.in_data;
                        state   <= (bus.in_data != '0) ? S_DATA : S_CSUM;
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        bus.ram_addr  <= wr_ptr;
                        bus.ram_wdata <= bus.in_data;
                        bus.ram_cs    <= 1'b1;
                        bus.ram_we    <= 1'b1;
                        bus.ram_oe    <= 1'b0;
                        wr_ptr        <= wr_ptr + ONE_A;
                        rem_cnt       <= rem_cnt - ONE_D;
                        checksum      <= checksum + bus.in_data;
                        words_loaded  <= words_loaded + ONE_D;
                        if (rem_cnt == ONE_D) begin
                            state <= S_CSUM;
                        end
                    end
                end

                S_CSUM: begin
                    if (xfer) begin
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b0;
                        if (bus.in_data == checksum) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            error <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader with a behavioural synchronous RAM.
// Inputs are driven and outputs sampled 2 time units after each rising edge.
module tb_ram_program_loader;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] pc_start;
    logic [DW-1:0] words_loaded;

    int errors = 0;
    int checks = 0;

    ram_program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .pc_start     (pc_start),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(2**AW)-1];
    int            wr_count = 0;

    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            wr_count          <= wr_count + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_cs !== 1'b0 || bus.ram_oe !== 1'b1) begin
            errors++;
            $display("FAIL idle_strobe cs/we/oe=%b%b%b expected 001",
                     bus.ram_cs, bus.ram_we, bus.ram_oe);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk);
        #2;
        load_start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic is_data);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready in_ready=%b expected 1 (word %h)", bus.in_ready, d);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.ram_we !== is_data || bus.ram_cs !== is_data || bus.ram_oe !== !is_data) begin
            errors++;
            $display("FAIL write_strobe cs/we/oe=%b%b%b expected %b%b%b (word %h)",
                     bus.ram_cs, bus.ram_we, bus.ram_oe, is_data, is_data, !is_data, d);
        end
        if (is_data) begin
            checks++;
            if (bus.ram_wdata !== d) begin
                errors++;
                $display("FAIL write_data ram_wdata=%h expected %h", bus.ram_wdata, d);
            end
        end
    endtask

    task automatic run_frame(input logic [DW-1:0] base, input logic [DW-1:0] len,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic [DW-1:0] d2, input logic [DW-1:0] csum,
                             input bit gaps);
        logic [DW-1:0] dw [3];
        dw[0] = d0;
        dw[1] = d1;
        dw[2] = d2;
        pulse_start();
        checks++;
        if ({busy, done, error, words_loaded} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL frame_start busy/done/error/words=%b%b%b/%h expected 100/0000",
                     busy, done, error, words_loaded);
        end
        send(base, 1'b0);
        send(len, 1'b0);
        for (int k = 0; k < int'(len); k++) begin
            if (gaps && k == 1) begin
                load_start = 1'b1;
                idle_cycle();
                load_start = 1'b0;
                checks++;
                if (busy !== 1'b1 || pc_start !== base[AW-1:0]) begin
                    errors++;
                    $display("FAIL midframe_start busy=%b pc_start=%h expected 1 %h",
                             busy, pc_start, base[AW-1:0]);
                end
            end
            send(dw[k], 1'b1);
            if (gaps && k == 2) idle_cycle();
        end
        send(csum, 1'b0);
    endtask

    task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                                input logic [AW-1:0] exp_pc, input logic [DW-1:0] exp_words);
        checks++;
        if ({done, error, busy, bus.in_ready} !== {exp_done, exp_err, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_flags done/error/busy/ready=%b%b%b%b expected %b%b00",
                     name, done, error, busy, bus.in_ready, exp_done, exp_err);
        end
        checks++;
        if (pc_start !== exp_pc) begin
            errors++;
            $display("FAIL %s_pc pc_start=%h expected %h", name, pc_start, exp_pc);
        end
        checks++;
        if (words_loaded !== exp_words) begin
            errors++;
            $display("FAIL %s_words words_loaded=%h expected %h", name, words_loaded, exp_words);
        end
    endtask

    task automatic check_mem(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        checks++;
        if (mem[a] !== exp) begin
            errors++;
            $display("FAIL %s_mem mem[%h]=%h expected %h", name, a, mem[a], exp);
        end
    endtask

    task automatic check_writes(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_writes count=%0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({bus.in_ready, bus.ram_cs, bus.ram_we, bus.ram_oe, busy, done, error} !== 7'b0001000) begin
            errors++;
            $display("FAIL %s_ctrl ready/cs/we/oe/busy/done/err=%b%b%b%b%b%b%b expected 0001000",
                     name, bus.in_ready, bus.ram_cs, bus.ram_we, bus.ram_oe, busy, done, error);
        end
        checks++;
        if (bus.ram_addr !== '0 || bus.ram_wdata !== '0 || pc_start !== '0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL %s_values addr/wdata/pc/words=%h/%h/%h/%h expected all zero",
                     name, bus.ram_addr, bus.ram_wdata, pc_start, words_loaded);
        end
    endtask

    task automatic test_reset();
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) idle_cycle();
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_mid_frame_reset();
        int w0 = wr_count;
        pulse_start();
        send(16'h0100, 1'b0);
        send(16'd3, 1'b0);
        send(16'h110C, 1'b1);
        send(16'h210E, 1'b1);
        idle_cycle();
        checks++;
        if (words_loaded !== 16'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prereset words/busy=%h/%b expected 0002/1", words_loaded, busy);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        check_mem("midframe_reset", 14'h0100, 16'h110C);
        check_mem("midframe_reset", 14'h0101, 16'h210E);
        check_writes("midframe_reset", wr_count - w0, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_good_frame();
        int w0 = wr_count;
        run_frame(16'h0100, 16'd3, 16'h110C, 16'h210E, 16'h110D, 16'h4327, 1'b0);
        check_status("good", 1'b1, 1'b0, 14'h0100, 16'd3);
        check_mem("good", 14'h0100, 16'h110C);
        check_mem("good", 14'h0101, 16'h210E);
        check_mem("good", 14'h0102, 16'h110D);
        check_writes("good", wr_count - w0, 3);
        idle_cycle();
    endtask

    task automatic test_bad_checksum();
        int w0 = wr_count;
        run_frame(16'h0100, 16'd3, 16'h110C, 16'h210E, 16'h110D, 16'h0000, 1'b0);
        check_status("bad_csum", 1'b0, 1'b1, 14'h0100, 16'd3);
        check_mem("bad_csum", 14'h0102, 16'h110D);
        check_writes("bad_csum", wr_count - w0, 3);
        idle_cycle();
    endtask

    task automatic test_zero_length();
        int w0 = wr_count;
        run_frame(16'h0200, 16'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        check_status("zero_len", 1'b1, 1'b0, 14'h0200, 16'd0);
        check_writes("zero_len", wr_count - w0, 0);
        idle_cycle();
    endtask

    task automatic test_addr_wrap();
        int w0 = wr_count;
        run_frame(16'h3FFF, 16'd2, 16'hFFFF, 16'h0002, 16'h0000, 16'h0001, 1'b0);
        check_status("wrap", 1'b1, 1'b0, 14'h3FFF, 16'd2);
        check_mem("wrap", 14'h3FFF, 16'hFFFF);
        check_mem("wrap", 14'h0000, 16'h0002);
        check_writes("wrap", wr_count - w0, 2);
        idle_cycle();
    endtask

    task automatic test_back_to_back_gaps();
        int w0 = wr_count;
        run_frame(16'h0100, 16'd3, 16'h110C, 16'h210E, 16'h110D, 16'h4327, 1'b1);
        check_status("gaps", 1'b1, 1'b0, 14'h0100, 16'd3);
        check_mem("gaps", 14'h0100, 16'h110C);
        check_mem("gaps", 14'h0101, 16'h210E);
        check_mem("gaps", 14'h0102, 16'h110D);
        check_writes("gaps", wr_count - w0, 3);
        idle_cycle();
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        test_mid_frame_reset();
        test_good_frame();
        test_bad_checksum();
        test_zero_length();
        test_addr_wrap();
        test_back_to_back_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
